// File: rtl/fetch_responder_pkg.sv
// Shared definitions for the fetch-bus responder: default widths, selector codes
// already used by the fetcher, and the responder FSM state encoding.
package fetch_responder_pkg;

    localparam int REG_WIDTH_DEF  = 8;
    localparam int ADDR_WIDTH_DEF = 16;

    localparam logic [15:0] RAM_MIRROR_TOP = 16'h1FFF;

    localparam logic [3:0] SELECTOR_MEM = 4'd0;
    localparam logic [3:0] SELECTOR_X   = 4'd1;
    localparam logic [3:0] SELECTOR_Y   = 4'd2;
    localparam logic [3:0] SELECTOR_A   = 4'd3;

    typedef enum logic [1:0] {
        RSP_IDLE = 2'd0,
        RSP_WAIT = 2'd1,
        RSP_RESP = 2'd2
    } rsp_state_e;

    function automatic logic sel_known(input logic [3:0] sel);
        return (sel == SELECTOR_MEM) || (sel == SELECTOR_X) ||
               (sel == SELECTOR_Y)   || (sel == SELECTOR_A);
    endfunction

endpackage

// File: rtl/resp_ram.sv
// Single-port synchronous byte RAM, write-first: a write also returns the new byte.
module resp_ram #(
    parameter int DEPTH = 2048,
    parameter int WIDTH = 8,
    parameter int AW    = $clog2(DEPTH)
) (
    input  logic             clk,
    input  logic             en,
    input  logic             we,
    input  logic [AW-1:0]    idx,
    input  logic [WIDTH-1:0] wdata,
    output logic [WIDTH-1:0] rdata
);

    logic [WIDTH-1:0] mem [DEPTH];

    always_ff @(posedge clk) begin
        if (en) begin
            if (we) begin
                mem[idx] <= wdata;
                rdata    <= wdata;
            end else begin
                rdata    <= mem[idx];
            end
        end
    end

endmodule

// File: rtl/fetch_responder.sv
// Responder end of the fetch/operand bus: serves mirrored internal RAM or the
// captured X/Y/A registers through an IDLE -> WAIT -> RESP handshake.
module fetch_responder
    import fetch_responder_pkg::*;
#(
    parameter int                    REG_WIDTH   = REG_WIDTH_DEF,
    parameter int                    ADDR_WIDTH  = ADDR_WIDTH_DEF,
    parameter int                    RAM_DEPTH   = 2048,
    parameter logic [ADDR_WIDTH-1:0] MIRROR_TOP  = ADDR_WIDTH'(RAM_MIRROR_TOP),
    parameter int                    WAIT_STATES = 1
) (
    input  logic                  phi1,
    input  logic                  reset,
    input  logic                  req,
    input  logic                  we,
    input  logic [3:0]            selector,
    input  logic [ADDR_WIDTH-1:0] addr,
    input  logic [REG_WIDTH-1:0]  wdata,
    input  logic [REG_WIDTH-1:0]  reg_x,
    input  logic [REG_WIDTH-1:0]  reg_y,
    input  logic [REG_WIDTH-1:0]  reg_a,
    output logic [REG_WIDTH-1:0]  data_out,
    output logic                  ready,
    output logic                  busy,
    output logic                  err
);

    localparam int         IDX_W     = $clog2(RAM_DEPTH);
    localparam logic [2:0] WAIT_INIT = (WAIT_STATES > 0) ? 3'(WAIT_STATES - 1) : 3'd0;

    rsp_state_e           state_q, state_d;
    logic [2:0]           cnt_q, cnt_d;
    logic [REG_WIDTH-1:0] obus_q;

    logic [3:0]           sel_q;
    logic                 we_q, bad_q;
    logic [IDX_W-1:0]     idx_q;
    logic [REG_WIDTH-1:0] wdata_q, hold_q;

    logic                 accept, bad_now, ram_en, ram_we;
    logic [IDX_W-1:0]     ram_idx;
    logic [REG_WIDTH-1:0] ram_rdata, hold_now, resp_data;

    assign accept = (state_q == RSP_IDLE) && req;

    always_comb begin
        hold_now = '0;
        case (selector)
            SELECTOR_X: hold_now = reg_x;
            SELECTOR_Y: hold_now = reg_y;
            SELECTOR_A: hold_now = reg_a;
            default:    hold_now = '0;
        endcase
    end

    // Illegal: unknown source, RAM access above the mirror, or a register write.
    assign bad_now = !sel_known(selector) ||
                     ((selector == SELECTOR_MEM) && (addr > MIRROR_TOP)) ||
                     ((selector != SELECTOR_MEM) && we);

    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        unique case (state_q)
            RSP_IDLE: begin
                if (req) begin
                    if ((selector == SELECTOR_MEM) && (WAIT_STATES > 0)) begin
                        state_d = RSP_WAIT;
                        cnt_d   = WAIT_INIT;
                    end else begin
                        state_d = RSP_RESP;
                    end
                end
            end
            RSP_WAIT: begin
                if (cnt_q == 3'd0) state_d = RSP_RESP;
                else               cnt_d   = cnt_q - 3'd1;
            end
            RSP_RESP: state_d = RSP_IDLE;
            default:  state_d = RSP_IDLE;
        endcase
    end

    always_ff @(posedge phi1) begin
        if (reset) begin
            state_q <= RSP_IDLE;
            cnt_q   <= '0;
            obus_q  <= '0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            if (state_q == RSP_RESP) obus_q <= resp_data;
        end
    end

    always_ff @(posedge phi1) begin
        if (accept) begin
            sel_q   <= selector;
            we_q    <= we;
            bad_q   <= bad_now;
            idx_q   <= addr[IDX_W-1:0];
            wdata_q <= wdata;
            hold_q  <= hold_now;
        end
    end

    // RAM is read at the accept edge and written at the RESP edge, so one port suffices.
    assign ram_we  = (state_q == RSP_RESP) && (sel_q == SELECTOR_MEM) && we_q && !bad_q && !reset;
    assign ram_en  = (accept && (selector == SELECTOR_MEM)) || ram_we;
    assign ram_idx = (state_q == RSP_IDLE) ? addr[IDX_W-1:0] : idx_q;

    resp_ram #(
        .DEPTH (RAM_DEPTH),
        .WIDTH (REG_WIDTH),
        .AW    (IDX_W)
    ) u_ram (
        .clk   (phi1),
        .en    (ram_en),
        .we    (ram_we),
        .idx   (ram_idx),
        .wdata (wdata_q),
        .rdata (ram_rdata)
    );

    always_comb begin
        resp_data = obus_q;
        if (!bad_q) begin
            if (sel_q == SELECTOR_MEM) resp_data = we_q ? wdata_q : ram_rdata;
            else                       resp_data = hold_q;
        end
    end

    assign ready    = (state_q == RSP_RESP);
    assign busy     = (state_q != RSP_IDLE);
    assign err      = ready && bad_q;
    assign data_out = ready ? resp_data : obus_q;

endmodule
